// File: rtl/risc6_pkg.sv
// Shared encodings for the risc6 sequencer: states, host commands,
// the halt word and the default stall opcode.
package risc6_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_CRST   = 3'd4
  } st_e;

  typedef enum logic [1:0] {
    C_RUN  = 2'd0,
    C_STEP = 2'd1,
    C_STOP = 2'd2,
    C_CRST = 2'd3
  } cmd_e;

  localparam logic [31:0] HLT_WORD    = 32'hFC00_0000;
  localparam logic [5:0]  HOLD_OP_DEF = 6'b000110;

endpackage

// File: rtl/risc6_imem.sv
// Instruction memory for the risc6 sequencer.
// One synchronous write port, one asynchronous read port, no reset.
module risc6_imem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/risc6_seq.sv
// Host-controlled sequencer: feeds instructions to a core from a local
// memory, with run/step/stop/core-reset commands and a run-length limit.
module risc6_seq
  import risc6_pkg::*;
#(
  parameter int          ADDR_W  = 8,
  parameter logic [5:0]  HOLD_OP = HOLD_OP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [31:0]       run_limit,
  input  logic [31:0]       core_pc,
  input  logic              core_halt,
  output logic [31:0]       instr,
  output logic              core_rst,
  output logic [2:0]        state,
  output logic [31:0]       issued_cnt,
  output logic              timeout,
  output logic              cmd_err
);

  st_e         r_state;
  st_e         w_next;
  logic [31:0] r_cnt;
  logic        r_to;
  logic        r_err;
  logic        r_core_rst;
  logic        r_crst_cnt;

  logic        w_exec;
  logic        w_in_range;
  logic        w_live;
  logic        w_oob;
  logic        w_ld;
  logic        w_acc;
  cmd_e        w_cmd;
  logic        w_ok;
  logic        w_err;
  logic        w_clr;
  logic        w_start;
  logic        w_to;
  logic        w_hit;
  logic [31:0] w_rdata;

  risc6_imem #(.ADDR_W(ADDR_W)) u_imem (
    .clk     (clk),
    .i_we    (w_ld),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (core_pc[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign w_exec     = (r_state == S_RUN || r_state == S_STEP) && !core_halt;
  assign w_in_range = (core_pc[31:ADDR_W] == '0);
  assign w_live     = w_exec && w_in_range;
  assign w_oob      = w_exec && !w_in_range;

  always_comb begin
    instr = {HOLD_OP, 2'b00, core_pc[23:0]};
    unique case (1'b1)
      w_live:  instr = w_rdata;
      w_oob:   instr = HLT_WORD;
      default: ;
    endcase
  end

  assign ld_ready  = (r_state == S_IDLE) || (r_state == S_HALTED);
  assign w_ld      = ld_valid && ld_ready;
  assign cmd_ready = !w_ld;
  assign w_acc     = cmd_valid && cmd_ready;
  assign w_cmd     = cmd_e'(cmd);

  assign w_ok = (w_cmd == C_CRST) ||
                (r_state == S_IDLE && (w_cmd == C_RUN || w_cmd == C_STEP)) ||
                (r_state == S_RUN && w_cmd == C_STOP);
  assign w_err = w_acc && !w_ok;

  // Limit counts the instruction issued on this very edge.
  assign w_hit = (run_limit != '0) &&
                 ((r_cnt + {31'b0, w_live}) == run_limit);

  always_comb begin
    w_next  = r_state;
    w_clr   = 1'b0;
    w_start = 1'b0;
    w_to    = 1'b0;
    if (w_acc && w_cmd == C_CRST) begin
      w_next = S_CRST;
      w_clr  = 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (core_halt) begin
            w_next = S_HALTED;
          end else if (w_acc && w_cmd == C_RUN) begin
            w_next  = S_RUN;
            w_start = 1'b1;
          end else if (w_acc && w_cmd == C_STEP) begin
            w_next = S_STEP;
          end
        end
        S_RUN: begin
          if (core_halt) begin
            w_next = S_HALTED;
          end else if (w_hit) begin
            w_next = S_HALTED;
            w_to   = 1'b1;
          end else if (w_acc && w_cmd == C_STOP) begin
            w_next = S_IDLE;
          end
        end
        S_STEP:   w_next = core_halt ? S_HALTED : S_IDLE;
        S_HALTED: ;
        S_CRST:   if (r_crst_cnt) w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_to       <= 1'b0;
      r_err      <= 1'b0;
      r_core_rst <= 1'b1;
      r_crst_cnt <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_err      <= w_err;
      r_core_rst <= (w_next == S_CRST);
      r_crst_cnt <= !w_clr && (r_state == S_CRST);
      if (w_clr || w_start) r_cnt <= '0;
      else if (w_live)      r_cnt <= r_cnt + 32'd1;
      if (w_start)   r_to <= 1'b0;
      else if (w_to) r_to <= 1'b1;
    end
  end

  assign state      = r_state;
  assign issued_cnt = r_cnt;
  assign timeout    = r_to;
  assign cmd_err    = r_err;
  assign core_rst   = r_core_rst;

endmodule

// File: tb/tb_risc6_seq.sv
// Directed bench for risc6_seq with a tiny behavioural core attached.
// Core ISA: op0 LDI rd,imm24; op1 ADD rd,rs1,rs2; op6 JMP imm24; op63 HLT.
module tb_risc6_seq;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_addr;
  logic [31:0] ld_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd;
  logic [31:0] run_limit;
  logic [31:0] core_pc;
  logic        core_halt;
  logic [31:0] instr;
  logic        core_rst;
  logic [2:0]  state;
  logic [31:0] issued_cnt;
  logic        timeout;
  logic        cmd_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_pc;
  logic        m_halt;
  logic [31:0] m_r [4];

  risc6_seq #(.ADDR_W(8), .HOLD_OP(6'b000110)) dut (
    .clk        (clk),
    .rst        (rst),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd        (cmd),
    .run_limit  (run_limit),
    .core_pc    (core_pc),
    .core_halt  (core_halt),
    .instr      (instr),
    .core_rst   (core_rst),
    .state      (state),
    .issued_cnt (issued_cnt),
    .timeout    (timeout),
    .cmd_err    (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign core_pc   = m_pc;
  assign core_halt = m_halt;

  always @(posedge clk) begin
    if (core_rst) begin
      m_pc   <= '0;
      m_halt <= 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] <= '0;
    end else if (!m_halt) begin
      case (instr[31:26])
        6'h00: begin
          m_r[instr[25:24]] <= {8'h0, instr[23:0]};
          m_pc <= m_pc + 32'd1;
        end
        6'h01: begin
          m_r[instr[25:24]] <= m_r[instr[23:22]] + m_r[instr[21:20]];
          m_pc <= m_pc + 32'd1;
        end
        6'h06:   m_pc <= {8'h0, instr[23:0]};
        6'h3F:   m_halt <= 1'b1;
        default: m_pc <= m_pc + 32'd1;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    tick;
    ld_valid = 1'b0;
  endtask

  task automatic command(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd       = c;
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget,
                            input string tag);
    for (int i = 0; i < budget && state !== st; i++) tick;
    chk(tag, {29'b0, state}, {29'b0, st});
  endtask

  initial begin
    rst = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    cmd_valid = 1'b0; cmd = 2'd0; run_limit = '0;
    #2 rst = 1'b1;
    #2;
    chk("rst_state", {29'b0, state}, 32'd0);
    chk("rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("rst_cnt", issued_cnt, 32'd0);
    chk("rst_timeout", {31'b0, timeout}, 32'd0);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    tick; tick;
    rst = 1'b0;
    tick;
    chk("core_rst_release", {31'b0, core_rst}, 32'd0);
    chk("ld_ready_idle", {31'b0, ld_ready}, 32'd1);

    command(2'd2);
    chk("stop_idle_err", {31'b0, cmd_err}, 32'd1);
    chk("stop_idle_state", {29'b0, state}, 32'd0);
    tick;
    chk("err_one_cycle", {31'b0, cmd_err}, 32'd0);

    load(8'd0, 32'h0100_0005);
    load(8'd1, 32'h0200_0003);
    load(8'd2, 32'h0760_0000);
    load(8'd3, 32'hFC00_0000);
    command(2'd0);
    chk("run_state", {29'b0, state}, 32'd1);
    chk("ld_ready_run", {31'b0, ld_ready}, 32'd0);
    wait_state(3'd3, 20, "progA_halted");
    chk("progA_cnt", issued_cnt, 32'd4);
    chk("progA_r3", m_r[3], 32'd8);
    chk("progA_timeout", {31'b0, timeout}, 32'd0);

    command(2'd0);
    chk("run_halted_err", {31'b0, cmd_err}, 32'd1);
    chk("run_halted_state", {29'b0, state}, 32'd3);
    tick;
    chk("run_halted_err_end", {31'b0, cmd_err}, 32'd0);

    command(2'd3);
    chk("crst_state0", {29'b0, state}, 32'd4);
    chk("crst_core_rst0", {31'b0, core_rst}, 32'd1);
    chk("crst_cnt", issued_cnt, 32'd0);
    tick;
    chk("crst_core_rst1", {31'b0, core_rst}, 32'd1);
    tick;
    chk("crst_done_state", {29'b0, state}, 32'd0);
    chk("crst_done_core_rst", {31'b0, core_rst}, 32'd0);
    chk("crst_core_pc", m_pc, 32'd0);

    command(2'd1);
    chk("step1_state", {29'b0, state}, 32'd2);
    chk("step1_instr", instr, 32'h0100_0005);
    tick;
    chk("step1_idle", {29'b0, state}, 32'd0);
    chk("step1_cnt", issued_cnt, 32'd1);
    command(2'd1);
    tick;
    chk("step2_idle", {29'b0, state}, 32'd0);
    chk("step2_cnt", issued_cnt, 32'd2);
    chk("step2_pc", m_pc, 32'd2);
    chk("step2_r2", m_r[2], 32'd3);

    command(2'd3);
    tick; tick;
    ld_valid = 1'b1; ld_addr = 8'd0; ld_data = 32'h1B00_0000;
    cmd_valid = 1'b1; cmd = 2'd0;
    #1;
    chk("coll_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    tick;
    chk("coll_state_idle", {29'b0, state}, 32'd0);
    ld_valid = 1'b0;
    #1;
    chk("coll_cmd_ready_after", {31'b0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
    chk("coll_run", {29'b0, state}, 32'd1);
    chk("coll_load_written", instr, 32'h1B00_0000);
    tick; tick; tick; tick; tick;
    chk("loop_cnt", issued_cnt, 32'd5);
    command(2'd2);
    chk("stop_state", {29'b0, state}, 32'd0);
    chk("stop_cnt", issued_cnt, 32'd6);
    chk("stop_hold_word", instr, 32'h1800_0000);
    tick; tick;
    chk("stop_pc_frozen", m_pc, 32'd0);
    chk("stop_cnt_frozen", issued_cnt, 32'd6);

    run_limit = 32'd10;
    command(2'd0);
    wait_state(3'd3, 30, "limit_halted");
    chk("limit_timeout", {31'b0, timeout}, 32'd1);
    chk("limit_cnt", issued_cnt, 32'd10);

    command(2'd3);
    tick; tick;
    run_limit = '0;
    command(2'd0);
    tick; tick;
    #2 rst = 1'b1;
    #1;
    chk("midrun_rst_state", {29'b0, state}, 32'd0);
    chk("midrun_rst_core_rst", {31'b0, core_rst}, 32'd1);
    chk("midrun_rst_instr", instr, 32'h1800_0000);
    tick;
    rst = 1'b0;
    tick;
    chk("post_rst_core_rst", {31'b0, core_rst}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
